// File: rtl/ptp_pkg.sv
// rtl/ptp_pkg.sv - shared types and constants for the ptp_frame serialiser
package ptp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } state_e;

  localparam logic [7:0] DEBUG_TAG = 8'hDB;
  localparam int         SEQ_W     = 8;

endpackage

// File: rtl/ptp_frame_next_ch.sv
// rtl/ptp_frame_next_ch.sv - find the lowest set mask bit strictly above idx_i
// (or the lowest set bit overall when first_i is high)
module ptp_next_ch #(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              first_i,
  output logic [IDX_W-1:0]  next_idx_o,
  output logic              found_o
);

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    next_idx_o = '0;
    found_o    = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask_i[k] && (first_i || (k > int'(idx_i)))) begin
        next_idx_o = IDX_W'(k);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptp_frame.sv
// rtl/ptp_frame.sv - framed snapshot serialiser: header beat with sequence
// number, then masked channels MSB first in word or bit-serial beats
module ptp_frame
  import ptp_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CH_W   = 32,
  parameter int OUT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH*CH_W-1:0]   values_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic                     bit_mode_i,
  input  logic                     debug_i,
  input  logic                     start_i,
  input  logic                     step_i,
  input  logic                     abort_i,
  output logic [OUT_W-1:0]         data_o,
  output logic                     valid_o,
  output logic                     sof_o,
  output logic                     eof_o,
  output logic                     busy_o
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = $clog2(CH_W);
  localparam logic [CH_W-1:0] LOW_MASK = {CH_W{1'b1}} >> 8;

  state_e                   state_q, state_d;
  logic [SEQ_W-1:0]         seq_q, seq_d;
  logic [NUM_CH*CH_W-1:0]   vals_q, vals_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic                     bit_mode_q, bit_mode_d;
  logic                     debug_q, debug_d;
  logic [IDX_W-1:0]         ch_idx_q, ch_idx_d;
  logic [BEAT_W-1:0]        beat_idx_q, beat_idx_d;
  logic [OUT_W-1:0]         data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sof_q, sof_d;
  logic                     eof_q, eof_d;

  logic [IDX_W-1:0]         adv_idx;
  logic                     adv_found;
  logic [BEAT_W-1:0]        last_beat;
  logic [CH_W-1:0]          chan;
  logic [BEAT_W-1:0]        sel;
  logic                     last_ch;

  ptp_next_ch #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_next_ch (
    .mask_i     (mask_q),
    .idx_i      (ch_idx_q),
    .first_i    (state_q == ST_HDR),
    .next_idx_o (adv_idx),
    .found_o    (adv_found)
  );

  assign last_beat = bit_mode_q ? BEAT_W'(CH_W - 1) : BEAT_W'(CH_W / OUT_W - 1);

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    vals_d     = vals_q;
    mask_d     = mask_q;
    bit_mode_d = bit_mode_q;
    debug_d    = debug_q;
    ch_idx_d   = ch_idx_q;
    beat_idx_d = beat_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          vals_d     = values_i;
          mask_d     = ch_mask_i;
          bit_mode_d = bit_mode_i;
          debug_d    = debug_i;
          state_d    = ST_HDR;
        end
      end
      ST_HDR, ST_DATA: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (step_i) begin
          if (state_q == ST_DATA && beat_idx_q != last_beat) begin
            beat_idx_d = beat_idx_q + 1'b1;
          end else if (adv_found) begin
            state_d    = ST_DATA;
            ch_idx_d   = adv_idx;
            beat_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
            seq_d   = seq_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output lookahead: the beat for the state being entered is registered now.
  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx_d == IDX_W'(k)) begin
        chan = debug_q ? ((CH_W'(DEBUG_TAG) << (CH_W - 8)) | (CH_W'(k) & LOW_MASK))
                       : vals_q[k*CH_W +: CH_W];
      end
    end
    last_ch = ((mask_q >> ch_idx_d) >> 1) == '0;
    sel     = '0;
    data_d  = '0;
    valid_d = (state_d != ST_IDLE);
    sof_d   = (state_d == ST_HDR);
    eof_d   = 1'b0;
    if (state_d == ST_HDR) begin
      data_d = OUT_W'(seq_q);
      eof_d  = (mask_d == '0);
    end else if (state_d == ST_DATA) begin
      if (bit_mode_q) begin
        sel    = BEAT_W'(CH_W - 1 - int'(beat_idx_d));
        data_d = OUT_W'(chan[sel]);
      end else begin
        sel    = BEAT_W'(CH_W - OUT_W - int'(beat_idx_d) * OUT_W);
        data_d = chan[sel +: OUT_W];
      end
      eof_d = (beat_idx_d == last_beat) && last_ch;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      vals_q     <= '0;
      mask_q     <= '0;
      bit_mode_q <= 1'b0;
      debug_q    <= 1'b0;
      ch_idx_q   <= '0;
      beat_idx_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      vals_q     <= vals_d;
      mask_q     <= mask_d;
      bit_mode_q <= bit_mode_d;
      debug_q    <= debug_d;
      ch_idx_q   <= ch_idx_d;
      beat_idx_q <= beat_idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ptp_frame.sv
// tb/tb_ptp_frame.sv - directed self-checking bench for ptp_frame
module tb_ptp_frame;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [159:0] values_i;
  logic [4:0]   ch_mask_i;
  logic         bit_mode_i;
  logic         debug_i;
  logic         start_i;
  logic         step_i;
  logic         abort_i;
  logic [7:0]   data_o;
  logic         valid_o;
  logic         sof_o;
  logic         eof_o;
  logic         busy_o;

  ptp_frame #(.NUM_CH(5), .CH_W(32), .OUT_W(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .values_i   (values_i),
    .ch_mask_i  (ch_mask_i),
    .bit_mode_i (bit_mode_i),
    .debug_i    (debug_i),
    .start_i    (start_i),
    .step_i     (step_i),
    .abort_i    (abort_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .sof_o      (sof_o),
    .eof_o      (eof_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_seq = 8'h00;
  logic [7:0] bdata [0:299];
  logic       beof  [0:299];
  int         n;
  int         eof_cnt;
  int         bad_flags;
  logic [7:0] acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    values_i[k*32 +: 32] = v;
  endtask

  // Runs one frame with step held high; optionally disturbs inputs or aborts at a beat.
  task automatic run_frame(input logic [4:0] mask, input logic bm, input logic dbg,
                           input int disturb_at, input int abort_at);
    logic done;
    ch_mask_i  = mask;
    bit_mode_i = bm;
    debug_i    = dbg;
    start_i    = 1'b1;
    tick();
    start_i   = 1'b0;
    n         = 0;
    done      = 1'b0;
    eof_cnt   = 0;
    bad_flags = 0;
    step_i    = 1'b1;
    while (!done && n < 300) begin
      bdata[n] = data_o;
      beof[n]  = eof_o;
      if (eof_o) eof_cnt++;
      if (!valid_o || !busy_o || (sof_o !== (n == 0))) bad_flags++;
      if (n == abort_at) abort_i = 1'b1;
      if (n == disturb_at) begin
        values_i   = ~values_i;
        ch_mask_i  = 5'h1F;
        bit_mode_i = ~bm;
        start_i    = 1'b1;
      end
      done = eof_o || (n == abort_at);
      n++;
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
    end
    step_i = 1'b0;
    check("frame_bounded", {31'b0, done}, 32'd1);
    check("hdr_seq", {24'b0, bdata[0]}, {24'b0, exp_seq});
    check("beat_flags", bad_flags, 0);
    check("eof_count", eof_cnt, (abort_at >= 0) ? 0 : 1);
    check("idle_valid", {31'b0, valid_o}, 32'd0);
    check("idle_busy", {31'b0, busy_o}, 32'd0);
    if (abort_at < 0) exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    reset_i    = 1'b1;
    values_i   = '0;
    ch_mask_i  = '0;
    bit_mode_i = 1'b0;
    debug_i    = 1'b0;
    start_i    = 1'b0;
    step_i     = 1'b0;
    abort_i    = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check("rst_data", {24'b0, data_o}, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_sof", {31'b0, sof_o}, 32'd0);
    check("rst_eof", {31'b0, eof_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);

    // Word frame, all channels
    set_ch(0, 32'h11223344);
    set_ch(1, 32'h55667788);
    set_ch(2, 32'h99AABBCC);
    set_ch(3, 32'hDDEEFF00);
    set_ch(4, 32'hAABBCCDD);
    run_frame(5'h1F, 1'b0, 1'b0, -1, -1);
    check("word_len", n, 21);
    check("word_hdr", {24'b0, bdata[0]}, 32'h00);
    check("word_b1", {24'b0, bdata[1]}, 32'h11);
    check("word_b2", {24'b0, bdata[2]}, 32'h22);
    check("word_b3", {24'b0, bdata[3]}, 32'h33);
    check("word_b4", {24'b0, bdata[4]}, 32'h44);
    check("word_b5", {24'b0, bdata[5]}, 32'h55);
    check("word_b17", {24'b0, bdata[17]}, 32'hAA);
    check("word_b18", {24'b0, bdata[18]}, 32'hBB);
    check("word_b19", {24'b0, bdata[19]}, 32'hCC);
    check("word_b20", {24'b0, bdata[20]}, 32'hDD);
    check("word_eof20", {31'b0, beof[20]}, 32'd1);

    // Bit-serial frame, channels 2 and 4
    set_ch(2, 32'h80000001);
    set_ch(4, 32'h00000000);
    run_frame(5'b10100, 1'b1, 1'b0, -1, -1);
    check("bit_len", n, 65);
    check("bit_hdr", {24'b0, bdata[0]}, 32'h01);
    check("bit_b1", {24'b0, bdata[1]}, 32'h01);
    check("bit_b2", {24'b0, bdata[2]}, 32'h00);
    check("bit_b31", {24'b0, bdata[31]}, 32'h00);
    check("bit_b32", {24'b0, bdata[32]}, 32'h01);
    acc = '0;
    for (int i = 33; i <= 64; i++) acc = acc | bdata[i];
    check("bit_ch4_zero", {24'b0, acc}, 32'h00);
    check("bit_eof64", {31'b0, beof[64]}, 32'd1);

    // Inputs changed and start pulsed mid-frame must not disturb the snapshot
    set_ch(0, 32'h11223344);
    run_frame(5'b00001, 1'b0, 1'b0, 2, -1);
    check("snap_len", n, 5);
    check("snap_b1", {24'b0, bdata[1]}, 32'h11);
    check("snap_b2", {24'b0, bdata[2]}, 32'h22);
    check("snap_b3", {24'b0, bdata[3]}, 32'h33);
    check("snap_b4", {24'b0, bdata[4]}, 32'h44);

    // Abort together with step on beat 5
    set_ch(0, 32'h11223344);
    set_ch(1, 32'h55667788);
    run_frame(5'h1F, 1'b0, 1'b0, -1, 5);
    check("abort_len", n, 6);
    check("abort_b5", {24'b0, bdata[5]}, 32'h55);

    // Debug pattern on channel 3; header repeats the aborted seq
    run_frame(5'b01000, 1'b0, 1'b1, -1, -1);
    check("dbg_hdr", {24'b0, bdata[0]}, 32'h03);
    check("dbg_len", n, 5);
    check("dbg_b1", {24'b0, bdata[1]}, 32'hDB);
    check("dbg_b2", {24'b0, bdata[2]}, 32'h00);
    check("dbg_b3", {24'b0, bdata[3]}, 32'h00);
    check("dbg_b4", {24'b0, bdata[4]}, 32'h03);

    // Empty mask: header only
    run_frame(5'b00000, 1'b0, 1'b0, -1, -1);
    check("empty_len", n, 1);
    check("empty_hdr", {24'b0, bdata[0]}, 32'h04);
    check("empty_eof", {31'b0, beof[0]}, 32'd1);

    // Asynchronous reset mid-frame
    set_ch(0, 32'h11223344);
    ch_mask_i = 5'h1F;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    step_i  = 1'b1;
    tick();
    tick();
    step_i = 1'b0;
    check("pre_rst_data", {24'b0, data_o}, 32'h22);
    reset_i = 1'b1;
    #1;
    check("mid_rst_data", {24'b0, data_o}, 32'd0);
    check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    check("mid_rst_sof", {31'b0, sof_o}, 32'd0);
    check("mid_rst_eof", {31'b0, eof_o}, 32'd0);
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    #2;
    reset_i = 1'b0;
    exp_seq = 8'h00;
    tick();
    run_frame(5'h1F, 1'b0, 1'b0, -1, -1);
    check("post_rst_hdr", {24'b0, bdata[0]}, 32'h00);

    // Sequence wrap
    while (exp_seq != 8'hFF) run_frame(5'b00000, 1'b0, 1'b0, -1, -1);
    run_frame(5'b00000, 1'b0, 1'b0, -1, -1);
    check("wrap_ff", {24'b0, bdata[0]}, 32'hFF);
    run_frame(5'b00000, 1'b0, 1'b0, -1, -1);
    check("wrap_00", {24'b0, bdata[0]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptp_frame.md
# ptp_frame

Parametrised framed output serialiser for the Manchester Baby debug/observation path. It takes a snapshot of NUM_CH channels of CH_W bits each (RAM data, address, accumulator, PI, CI, ...) when a frame is started. It then streams the snapshot onto an OUT_W-bit pin bus, one beat per step_i, in either word-wide or bit-serial mode. Each frame opens with a sequence-number header beat and carries sof/eof/valid markers, so the off-chip reader can frame it without counting edges. A per-frame channel mask skips unwanted channels.

## Interface
- NUM_CH, 5, number of input channels (1..16)
- CH_W, 32, bits per channel; multiple of OUT_W, >= 8
- OUT_W, 8, output bus width (>= 1)
- clk_i  in  1  clock, rising edge
- reset_i  in  1  reset, asynchronous, active-high
- values_i  in  NUM_CH*CH_W  flattened channels; channel k = values_i[k*CH_W +: CH_W]
- ch_mask_i  in  NUM_CH  bit k=1 includes channel k in the frame
- bit_mode_i  in  1  0 = word mode (OUT_W bits/beat), 1 = bit-serial (1 bit/beat)
- debug_i  in  1  substitute debug pattern for channel data
- start_i  in  1  request a new frame (sampled in IDLE only)
- step_i  in  1  advance one beat
- abort_i  in  1  abandon the current frame
- data_o  out  OUT_W  current beat
- valid_o  out  1  data_o holds a frame beat
- sof_o  out  1  current beat is the header
- eof_o  out  1  current beat is the last of the frame
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, HDR, DATA.
- **IDLE, start_i=1:**
  - Capture values_i, ch_mask_i, bit_mode_i and debug_i into snapshot registers.
  - Go to HDR.
  - Inputs other than step_i/abort_i are ignored until the frame ends.
- **HDR beat:**
  - data_o = seq_q[OUT_W-1:0], zero-extended if OUT_W > 8.
  - sof_o = 1, valid_o = 1.
  - eof_o = 1 if the captured mask is all zero.
- **HDR, step_i:**
  - If the mask is non-zero: go to DATA at the lowest-indexed set mask bit, beat 0.
  - Otherwise: go to IDLE and increment seq_q.
- **DATA ordering:**
  - Channels are sent in ascending index; masked-off channels are skipped with no beat.
  - Within a channel, data is sent MSB first.
  - Word mode: beat b = chan[CH_W-1 - b*OUT_W -: OUT_W], CH_W/OUT_W beats per channel.
  - Bit mode: data_o = {zeros, chan[CH_W-1-b]}, CH_W beats per channel.
- **Debug channel k:** top 8 bits are 8'hDB; remaining bits are k, zero-extended.
- **eof_o** = 1 on the last beat of the last enabled channel. A step on that beat goes to IDLE and increments seq_q (8-bit, wraps 255 -> 0).
- **abort_i:** in any state other than IDLE, go to IDLE next edge; seq_q is unchanged. abort_i takes priority over step_i.
- **start_i outside IDLE:** ignored. start_i and step_i together in IDLE: start only.
- step_i in IDLE: no effect.

## Timing
- **Reset values:**
  - data_o = 0, valid_o = 0, sof_o = 0, eof_o = 0, busy_o = 0.
  - seq_q = 0, state = IDLE.
  - Snapshot registers cleared.
- **Reset mid-frame:** all of the above take effect immediately (asynchronous); the frame is lost.
- **Output registering:** all outputs are registered.
  - The header appears the cycle after the start_i edge.
  - Each step_i edge presents the next beat on the following cycle.
- **Back-to-back frames:** a frame ends into IDLE (valid_o = 0) for at least one cycle before the next start_i is taken.
- **Frame length:** 1 + popcount(mask) * (bit_mode ? CH_W : CH_W/OUT_W) beats.

## Structure
- **Package ptp_pkg:**
  - state enum.
  - DEBUG_TAG = 8'hDB.
  - SEQ_W = 8.
- **Sub-module ptp_next_ch:**
  - Combinational find-next-set-bit over the mask, strictly above a given index.
  - Outputs: next index and a found flag.
  - Used both at HDR exit and at each channel end.
- **Counters:**
  - ch_idx: $clog2(NUM_CH) bits.
  - beat_idx: $clog2(CH_W) bits; terminal value depends on the captured mode.

## Test plan
- **Reset:** assert reset_i mid-frame -> every output reads 0 immediately; busy_o = 0; next frame header is 8'h00.
- **Word frame:**
  - Setup: mask 5'h1F; ch0 = 32'h11223344, ch4 = 32'hAABBCCDD.
  - Header: data_o = 8'h00 with sof_o.
  - Beats 1-4: 11, 22, 33, 44.
  - Beats 17-20: AA, BB, CC, DD, with eof on beat 20.
  - Total: 21 beats; the next frame header is 8'h01.
- **Bit mode with mask:**
  - Setup: mask 5'b10100; ch2 = 32'h80000001; ch4 = 0.
  - Response: header, then 64 beats; beat 1 = 8'h01, beat 32 = 8'h01, beats 33-64 = 0, with eof on beat 64.
- **Snapshot and ignore rules:** change values_i and pulse start_i mid-frame -> the streamed data and frame length are unchanged.
- **Abort:** abort_i together with step_i on beat 5 -> IDLE next cycle, valid_o = 0; the following header repeats the same seq.
- **Debug and empty mask:**
  - Debug, mask 5'b01000 -> beats 8'hDB, 00, 00, 03.
  - Mask 0 -> single header beat with sof_o = eof_o = 1; seq increments.
  - 256 frames -> seq wraps to 8'h00.
